alu_share_arbiter: RTL

Sequencer that shares the single 64-bit combinational ALU slice between two requesters: execute-stage issue (requester 0) and address-generation (requester 1). It arbitrates, registers the granted operands into the ALU, and captures the result and N/Z/V/C flags one cycle later. It holds the result on a valid/ready output until it is consumed, and maintains the architectural NZCV flag register for flag-setting operations.

---
 rtl/alu_share_arbiter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU slice between execute issue (r0) and address generation (r1).
// Define ALU_ARB_FIXED_PRIO_EN for fixed r0 priority; default build arbitrates round-robin.
module alu_share_arbiter #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             r0_valid,
  input  logic             r1_valid,
  output logic             r0_ready,
  output logic             r1_ready,
  input  logic [WIDTH-1:0] r0_a,
  input  logic [WIDTH-1:0] r0_b,
  input  logic [WIDTH-1:0] r1_a,
  input  logic [WIDTH-1:0] r1_b,
  input  logic [2:0]       r0_op,
  input  logic [2:0]       r1_op,
  input  logic             r0_setf,
  input  logic             r1_setf,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_select,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_negative,
  input  logic             alu_zero,
  input  logic             alu_overflow,
  input  logic             alu_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_id,
  output logic [3:0]       nzcv,
  input  logic             flush
);

  localparam int unsigned ST_W = 2;
  localparam logic [ST_W-1:0] IDLE = 2'd0;
  localparam logic [ST_W-1:0] EXEC = 2'd1;
  localparam logic [ST_W-1:0] DONE = 2'd2;

  logic [ST_W-1:0] state;
  logic [ST_W-1:0] state_next;
  logic            grant;
  logic            accept;
  logic            setf_q;
  logic            id_q;

`ifdef ALU_ARB_FIXED_PRIO_EN
  // r0 wins any contention
  always_comb begin
    grant = ~r0_valid & r1_valid;
  end
`else
  logic last_grant;

  // Contention goes to whichever requester did not win last
  always_comb begin
    grant = 1'b0;
    if (r0_valid && r1_valid) begin
      grant = ~last_grant;
    end else begin
      grant = ~r0_valid & r1_valid;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and handshake; ready is suppressed while reset is asserted
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    r0_ready   = 1'b0;
    r1_ready   = 1'b0;
    case (state)
      IDLE: begin
        if (reset_n && !flush && (r0_valid || r1_valid)) begin
          accept     = 1'b1;
          r0_ready   = ~grant;
          r1_ready   = grant;
          state_next = EXEC;
        end
      end
      EXEC: begin
        state_next = flush ? IDLE : DONE;
      end
      DONE: begin
        if (flush || out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Operand capture on accept, result and flag capture at the end of EXEC
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_select <= 3'd0;
      setf_q     <= 1'b0;
      id_q       <= 1'b0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_id     <= 1'b0;
      nzcv       <= 4'b0000;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_grant <= 1'b1;
`endif
    end else begin
      out_valid <= (state_next == DONE);
      if (accept) begin
        alu_a      <= grant ? r1_a : r0_a;
        alu_b      <= grant ? r1_b : r0_b;
        alu_select <= grant ? r1_op : r0_op;
        setf_q     <= grant ? r1_setf : r0_setf;
        id_q       <= grant;
`ifndef ALU_ARB_FIXED_PRIO_EN
        last_grant <= grant;
`endif
      end
      if ((state == EXEC) && !flush) begin
        out_result <= alu_result;
        out_id     <= id_q;
        if (setf_q) begin
          nzcv <= {alu_negative, alu_zero, alu_carry, alu_overflow};
        end
      end
    end
  end

endmodule
